starforc_colmix: RTL
====================

# starforc_colmix

Colour mixer and palette stage sitting directly downstream of the video board's sprite line-buffer and character serializers. It takes per-pixel sprite (OV/OC), character (SV/SC) and two background-layer codes plus composite blank. It resolves layer priority and transparency, looks the winner up in a 512-entry CPU-writable palette RAM, and emits registered RGB with aligned blanking. CPU palette accesses are buffered and slotted into cycles the video pipeline does not use.

## Interface
Parameters:
- `PRIO_SPR_OVER_CHR`, default 1: 1 = sprite above character; 0 = character above sprite.

Ports:
- `clk48m`  in  1  system clock; all logic on its rising edge.
- `nRESET`  in  1  asynchronous, active-low reset.
- `pix_en`  in  1  pixel-clock enable; high for 1 cycle in 8, never on 2 consecutive cycles.
- `OV`  in  3  sprite pixel value; 0 = transparent.
- `OC`  in  5  sprite colour.
- `SV`  in  3  character pixel value; 0 = transparent.
- `SC`  in  3  character colour.
- `B1V`, `B2V`  in  3 each  background-1 and background-2 pixel values; 0 = transparent.
- `B1C`, `B2C`  in  3 each  background-1 and background-2 colours.
- `nCMPBLK`  in  1  composite blank; low = blank.
- `CPU_A`  in  9  CPU palette address.
- `nCS_PAL`  in  1  palette chip select, active low.
- `nMEWR`, `nMERD`  in  1 each  CPU write and read strobes, active low.
- `DCON_in`  in  8  CPU write data.
- `DCON_out`  out  8  CPU read data; 0 when not reading.
- `R`, `G`  out  3 each  red and green.
- `B`  out  2  blue.
- `nBLANK_o`  out  1  blank aligned to RGB; low = blank.

## Operation
- Palette: 512 × 8 single-port RAM. Byte format is {B[1:0], G[2:0], R[2:0]}. Contents are not reset.
- Index per pixel is chosen by the first non-transparent layer in this order:
  - sprite: {1, OC, OV}
  - character: {000, SC, SV}
  - background 1: {001, B1C, B1V}
  - background 2: {010, B2C, B2V}
  - nothing visible: 9'h000
- With `PRIO_SPR_OVER_CHR` = 0, the sprite and character order swaps.
- Video pipeline advances only on `pix_en`:
  - S0 registers all layer inputs and `nCMPBLK`.
  - S1 computes and registers the index.
  - S2 performs the RAM read.
  - S3 registers RGB and `nBLANK_o`.
- While the aligned blank is low, RGB outputs are forced to 0.
- CPU write, FSM IDLE → PEND → IDLE:
  - Falling edge of (~`nCS_PAL` & ~`nMEWR`), detected on registered strobe, latches `CPU_A` and `DCON_in`, then goes to PEND.
  - PEND commits on the first cycle with `pix_en` = 0, then returns to IDLE.
  - A new write edge while in PEND overwrites the buffer; the older write is lost.
- RAM port arbitration: `pix_en` cycles belong to video; other cycles serve the CPU (write commit before read capture).
- `nRESET` low: FSM goes to IDLE, any pending write is dropped, all pipeline registers clear.

## Timing
- Reset values:
  - `R`, `G`, `B`: 0
  - `nBLANK_o`: 0
  - `DCON_out`: 0
  - all pipeline stages: index 0 and blank low
- Latency: pixel on the inputs at `pix_en` edge k appears on RGB after `pix_en` edge k+3. Outputs are stable for 8 clocks.
- Write commit occurs ≤2 clocks after the edge is detected, because `pix_en` is never high twice in a row.
- A video read of the same address in the same pixel as the commit returns the new data only if the commit precedes the S2 read cycle.
- Edge detection adds 1 clock. A strobe held low for many cycles produces exactly one write.
- Simultaneous read and write strobes: the write takes precedence and no read capture happens.
- Reset asserted mid-PEND: the write is not performed.

## Configuration
- `STARFORC_PAL_READBACK_EN` defined:
  - A read-strobe falling edge (~`nCS_PAL` & ~`nMERD`) captures RAM[`CPU_A`] in the first non-`pix_en` cycle with no pending write.
  - `DCON_out` drives the captured byte while both strobes stay low, and 0 otherwise.
  - Capture latency is ≤3 clocks after the edge.
- Not defined: `DCON_out` is constant 0, with no read FSM or capture register.

## Test plan
- Reset then idle: after `nRESET` rises, RGB = 0 and `nBLANK_o` = 0 until 4 `pix_en` with `nCMPBLK` = 1. Then RGB = RAM[0x000].
- Priority: write RAM[0x10D] = 8'hFF and RAM[0x02B] = 8'h07. Drive OV = 5, OC = 1, SV = 3, SC = 5.
  - Expect RGB 7/7/3 at k+3.
  - Set OV = 0 → expect R = 7, G = 0, B = 0.
  - With `PRIO_SPR_OVER_CHR` = 0 and both layers set → expect R = 7, G = 0, B = 0.
- Write during active video:
  - Assert the write strobe to 0x1FF with data 8'hA5 for 20 clocks → exactly one commit, not on a `pix_en` cycle.
  - Sprite pixel {1, 5'h1F, 3'h7} → R = 5, G = 4, B = 2.
- Back-to-back writes: two write edges to 0x001 (8'h11, then 8'h22) 1 clock apart → RAM[0x001] = 8'h22.
- Blank: `nCMPBLK` = 0 with a visible sprite → RGB = 0 and `nBLANK_o` = 0, aligned at k+3.
- Reset mid-PEND: pulse `nRESET` between the edge and the commit → the RAM location is unchanged. Readback (macro on) of 0x1FF returns 8'hA5 within 3 clocks; with the macro off, `DCON_out` stays 0.

Source files
------------

// File: rtl/starforc_colmix.sv
// starforc_colmix: layer priority mixer feeding a 512x8 CPU-writable palette, registered RGB out.
// Optional CPU palette readback is built when STARFORC_PAL_READBACK_EN is defined.
module starforc_colmix #(
    parameter logic PRIO_SPR_OVER_CHR = 1'b1
) (
    input  logic       clk48m,
    input  logic       nRESET,
    input  logic       pix_en,
    input  logic [2:0] OV,
    input  logic [4:0] OC,
    input  logic [2:0] SV,
    input  logic [2:0] SC,
    input  logic [2:0] B1V,
    input  logic [2:0] B2V,
    input  logic [2:0] B1C,
    input  logic [2:0] B2C,
    input  logic       nCMPBLK,
    input  logic [8:0] CPU_A,
    input  logic       nCS_PAL,
    input  logic       nMEWR,
    input  logic       nMERD,
    input  logic [7:0] DCON_in,
    output logic [7:0] DCON_out,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [1:0] B,
    output logic       nBLANK_o
);
    localparam logic [0:0] WR_IDLE = 1'b0;
    localparam logic [0:0] WR_PEND = 1'b1;

    // Layer fields packed as {OV, OC, SV, SC, B1V, B1C, B2V, B2C}.
    function automatic logic [8:0] mix_index(input logic [25:0] lay, input logic spr_first);
        logic spr_vis;
        logic chr_vis;
        spr_vis = (lay[25:23] != 3'd0);
        chr_vis = (lay[17:15] != 3'd0);
        if (spr_first && spr_vis) begin
            mix_index = {1'b1, lay[22:18], lay[25:23]};
        end else if (chr_vis) begin
            mix_index = {3'b000, lay[14:12], lay[17:15]};
        end else if (spr_vis) begin
            mix_index = {1'b1, lay[22:18], lay[25:23]};
        end else if (lay[11:9] != 3'd0) begin
            mix_index = {3'b001, lay[8:6], lay[11:9]};
        end else if (lay[5:3] != 3'd0) begin
            mix_index = {3'b010, lay[2:0], lay[5:3]};
        end else begin
            mix_index = 9'h000;
        end
    endfunction

    logic [25:0] lay_q, lay_d;
    logic        blk0_q, blk0_d;
    logic [8:0]  idx1_q, idx1_d;
    logic        blk1_q, blk1_d;
    logic        blk2_q, blk2_d;
    logic        pix_q, pix_d;
    logic [7:0]  vid_dat_q, vid_dat_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        nblank_q, nblank_d;

    logic        wr_sq_q, wr_sq_d;
    logic        wr_sq2_q, wr_sq2_d;
    logic [8:0]  cpu_a_q, cpu_a_d;
    logic [7:0]  cpu_d_q, cpu_d_d;
    logic [0:0]  wr_st_q, wr_st_d;
    logic [8:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        wr_edge_s;
    logic        ram_we_s;
    logic [8:0]  ram_addr_s;

    logic [7:0]  pal_mem [0:511];
    logic [7:0]  ram_rd_q;

    // Video pipeline: all four stages advance together on pix_en.
    always_comb begin
        lay_d     = lay_q;
        blk0_d    = blk0_q;
        idx1_d    = idx1_q;
        blk1_d    = blk1_q;
        blk2_d    = blk2_q;
        rgb_d     = rgb_q;
        nblank_d  = nblank_q;
        pix_d     = pix_en;
        if (pix_en) begin
            lay_d    = {OV, OC, SV, SC, B1V, B1C, B2V, B2C};
            blk0_d   = nCMPBLK;
            idx1_d   = mix_index(lay_q, PRIO_SPR_OVER_CHR);
            blk1_d   = blk0_q;
            blk2_d   = blk1_q;
            nblank_d = blk2_q;
            rgb_d    = blk2_q ? vid_dat_q : 8'h00;
        end else begin
            nblank_d = nblank_q;
        end
        // The shared RAM read register is only video data right after a pix_en cycle.
        if (pix_q) begin
            vid_dat_d = ram_rd_q;
        end else begin
            vid_dat_d = vid_dat_q;
        end
    end

    // CPU write buffer: edge-detect the registered strobe, commit on a free cycle.
    always_comb begin
        wr_sq_d   = ~nCS_PAL & ~nMEWR;
        wr_sq2_d  = wr_sq_q;
        cpu_a_d   = CPU_A;
        cpu_d_d   = DCON_in;
        wr_edge_s = wr_sq_q & ~wr_sq2_q;
        wr_st_d   = wr_st_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ram_we_s  = 1'b0;
        case (wr_st_q)
            WR_IDLE: begin
                if (wr_edge_s) begin
                    wr_addr_d = cpu_a_q;
                    wr_data_d = cpu_d_q;
                    wr_st_d   = WR_PEND;
                end else begin
                    wr_st_d   = WR_IDLE;
                end
            end
            WR_PEND: begin
                if (wr_edge_s) begin
                    wr_addr_d = cpu_a_q;
                    wr_data_d = cpu_d_q;
                    wr_st_d   = WR_PEND;
                end else if (!pix_en) begin
                    ram_we_s  = 1'b1;
                    wr_st_d   = WR_IDLE;
                end else begin
                    wr_st_d   = WR_PEND;
                end
            end
            default: begin
                wr_st_d = WR_IDLE;
            end
        endcase
    end

`ifdef STARFORC_PAL_READBACK_EN
    logic       rd_sq_q, rd_sq_d;
    logic       rd_sq2_q, rd_sq2_d;
    logic       rd_pend_q, rd_pend_d;
    logic [8:0] rd_addr_q, rd_addr_d;
    logic       cap_go_q, cap_go_s;
    logic [7:0] cap_q, cap_d;
    logic       cap_ok_q, cap_ok_d;
    logic [7:0] dcon_q, dcon_d;
    logic       rd_edge_s;
    logic       rd_act_s;

    // CPU readback: a read edge queues a capture that waits for a free, write-idle cycle.
    always_comb begin
        rd_act_s  = ~nCS_PAL & ~nMERD;
        rd_sq_d   = rd_act_s & nMEWR;
        rd_sq2_d  = rd_sq_q;
        rd_edge_s = rd_sq_q & ~rd_sq2_q;
        cap_go_s  = rd_pend_q & ~rd_edge_s & ~pix_en & (wr_st_q == WR_IDLE) & ~wr_edge_s;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        if (rd_edge_s) begin
            rd_pend_d = 1'b1;
            rd_addr_d = cpu_a_q;
        end else if (cap_go_s) begin
            rd_pend_d = 1'b0;
        end else begin
            rd_pend_d = rd_pend_q;
        end
        cap_d = cap_go_q ? ram_rd_q : cap_q;
        if (!rd_act_s) begin
            cap_ok_d = 1'b0;
        end else if (cap_go_q) begin
            cap_ok_d = 1'b1;
        end else begin
            cap_ok_d = cap_ok_q;
        end
        dcon_d = (rd_act_s && cap_ok_q) ? cap_q : 8'h00;
    end

    // Readback registers.
    always_ff @(posedge clk48m or negedge nRESET) begin
        if (!nRESET) begin
            rd_sq_q   <= 1'b0;
            rd_sq2_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= 9'h000;
            cap_go_q  <= 1'b0;
            cap_q     <= 8'h00;
            cap_ok_q  <= 1'b0;
            dcon_q    <= 8'h00;
        end else begin
            rd_sq_q   <= rd_sq_d;
            rd_sq2_q  <= rd_sq2_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            cap_go_q  <= cap_go_s;
            cap_q     <= cap_d;
            cap_ok_q  <= cap_ok_d;
            dcon_q    <= dcon_d;
        end
    end

    assign DCON_out = dcon_q;
`else
    logic unused_rd_s;
    assign unused_rd_s = nMERD;
    assign DCON_out    = 8'h00;
`endif

    // RAM port owner: video on pix_en, else a committing write, else the readback address.
    always_comb begin
        if (pix_en) begin
            ram_addr_s = idx1_q;
        end else if (ram_we_s) begin
            ram_addr_s = wr_addr_q;
        end else begin
`ifdef STARFORC_PAL_READBACK_EN
            ram_addr_s = rd_addr_q;
`else
            ram_addr_s = wr_addr_q;
`endif
        end
    end

    // Palette RAM: contents and read register are intentionally not reset.
    always_ff @(posedge clk48m) begin
        if (ram_we_s) begin
            pal_mem[ram_addr_s] <= wr_data_q;
        end
        ram_rd_q <= pal_mem[ram_addr_s];
    end

    // Pipeline, strobe and write-buffer registers.
    always_ff @(posedge clk48m or negedge nRESET) begin
        if (!nRESET) begin
            lay_q     <= 26'd0;
            blk0_q    <= 1'b0;
            idx1_q    <= 9'h000;
            blk1_q    <= 1'b0;
            blk2_q    <= 1'b0;
            pix_q     <= 1'b0;
            vid_dat_q <= 8'h00;
            rgb_q     <= 8'h00;
            nblank_q  <= 1'b0;
            wr_sq_q   <= 1'b0;
            wr_sq2_q  <= 1'b0;
            cpu_a_q   <= 9'h000;
            cpu_d_q   <= 8'h00;
            wr_st_q   <= WR_IDLE;
            wr_addr_q <= 9'h000;
            wr_data_q <= 8'h00;
        end else begin
            lay_q     <= lay_d;
            blk0_q    <= blk0_d;
            idx1_q    <= idx1_d;
            blk1_q    <= blk1_d;
            blk2_q    <= blk2_d;
            pix_q     <= pix_d;
            vid_dat_q <= vid_dat_d;
            rgb_q     <= rgb_d;
            nblank_q  <= nblank_d;
            wr_sq_q   <= wr_sq_d;
            wr_sq2_q  <= wr_sq2_d;
            cpu_a_q   <= cpu_a_d;
            cpu_d_q   <= cpu_d_d;
            wr_st_q   <= wr_st_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign R        = rgb_q[2:0];
    assign G        = rgb_q[5:3];
    assign B        = rgb_q[7:6];
    assign nBLANK_o = nblank_q;

endmodule
